// File: rtl/uart_tx_cmd_queue.sv
// rtl/uart_tx_cmd_queue.sv - command queue and pacing sequencer feeding UART_TX_DATA
module uart_tx_cmd_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int GAP_CYCLES   = 20,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              I_clk_10M,
  input  logic              I_rst_n,
  input  logic [63:0]       I_wr_data,
  input  logic              I_wr_en,
  input  logic              I_flush,
  output logic              O_full,
  output logic              O_empty,
  output logic [ADDR_W:0]   O_level,
  output logic [63:0]       O_data,
  output logic              O_data_valid,
  input  logic              I_tx_ready,
  output logic              O_busy,
  output logic [15:0]       O_sent_cnt,
  output logic              O_overflow,
  output logic              O_timeout
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [63:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [15:0]      sent_q, sent_d;
  logic             timeout_q, timeout_d;

  logic push;
  logic ovf_hit;
  logic launch;
  logic timer_last;
  logic gap_last;

  // A flush swallows any push in the same cycle; full is judged on the pre-edge level,
  // so a simultaneous pop never frees a slot for a push.
  assign push       = I_wr_en && !I_flush && !full_q;
  assign ovf_hit    = I_wr_en && !I_flush && full_q;
  assign launch     = (state_q == S_IDLE) && !empty_q && I_tx_ready && !I_flush;
  assign timer_last = (timer_q == TMR_W'(BUSY_TIMEOUT - 1));
  assign gap_last   = (gap_q == GAP_W'(GAP_CYCLES - 1));

  // Command storage; contents are deliberately left unreset.
  always_ff @(posedge I_clk_10M) begin
    if (push) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= I_wr_data;
    end
  end

  // Queue bookkeeping: pointers, level and the flags derived from the next level.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (I_flush) begin
      rd_ptr_d   = wr_ptr_q;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (launch) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !launch) begin
        level_d = level_q + PTR_W'(1);
      end else if (!push && launch) begin
        level_d = level_q - PTR_W'(1);
      end
      if (ovf_hit) begin
        overflow_d = 1'b1;
      end
    end
    full_d  = (level_d == PTR_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Queue state registers.
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Sequencer state register.
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state: launch, wait for TX to go busy, wait for it to finish, pace.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!I_tx_ready) begin
          state_d = S_WAIT_DONE;
        end else if (timer_last) begin
          state_d = S_GAP;
        end
      end
      S_WAIT_DONE: begin
        if (I_tx_ready) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer outputs: data capture, valid pulse, timers, frame counter, timeout flag.
  always_comb begin
    timer_d   = '0;
    gap_d     = '0;
    data_d    = data_q;
    sent_d    = sent_q;
    timeout_d = I_flush ? 1'b0 : timeout_q;
    valid_d   = (state_d == S_LAUNCH);
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          data_d = mem[rd_ptr_q[ADDR_W-1:0]];
        end
      end
      S_WAIT_BUSY: begin
        timer_d = timer_q + TMR_W'(1);
        if (I_tx_ready && timer_last) begin
          timeout_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (I_tx_ready) begin
          sent_d = sent_q + 16'd1;
        end
      end
      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
      end
      default: begin
      end
    endcase
  end

  // Sequencer output registers.
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      timer_q   <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sent_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sent_q    <= sent_d;
      timeout_q <= timeout_d;
    end
  end

  assign O_full       = full_q;
  assign O_empty      = empty_q;
  assign O_level      = level_q;
  assign O_data       = data_q;
  assign O_data_valid = valid_q;
  assign O_busy       = (state_q != S_IDLE);
  assign O_sent_cnt   = sent_q;
  assign O_overflow   = overflow_q;
  assign O_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_cmd_queue.sv
// tb/tb_uart_tx_cmd_queue.sv - self-checking bench for uart_tx_cmd_queue
`timescale 1ns/1ps
module tb_uart_tx_cmd_queue;

  localparam int GAP = 20;
  localparam int LOW_CYCLES = 110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        flush = 1'b0;
  logic        tx_ready = 1'b1;

  logic        full, empty, valid, busy, ovf, tmo;
  logic [4:0]  level;
  logic [63:0] data;
  logic [15:0] sent;

  int n_checks = 0;
  int n_fail = 0;
  int launches = 0;
  logic [63:0] sb[$];

  // TX model: 0 = normal (ready low 110 cycles starting 2 after valid), 1 = never busy, 2 = stalled
  int tx_mode = 0;
  int tx_dly = 0;
  int tx_low = 0;
  bit prev_valid = 1'b0;
  logic [63:0] held_data = '0;

  always #50 clk = ~clk;

  uart_tx_cmd_queue dut (
    .I_clk_10M   (clk),
    .I_rst_n     (rst_n),
    .I_wr_data   (wr_data),
    .I_wr_en     (wr_en),
    .I_flush     (flush),
    .O_full      (full),
    .O_empty     (empty),
    .O_level     (level),
    .O_data      (data),
    .O_data_valid(valid),
    .I_tx_ready  (tx_ready),
    .O_busy      (busy),
    .O_sent_cnt  (sent),
    .O_overflow  (ovf),
    .O_timeout   (tmo)
  );

  always @(negedge clk) begin
    if (tx_mode == 1) begin
      tx_ready = 1'b1; tx_dly = 0; tx_low = 0;
    end else if (tx_mode == 2) begin
      tx_ready = 1'b0; tx_dly = 0; tx_low = 0;
    end else if (rst_n && valid) begin
      tx_dly = 2;
    end else if (tx_dly > 0) begin
      tx_dly--;
      if (tx_dly == 0) begin
        tx_ready = 1'b0;
        tx_low = LOW_CYCLES;
      end
    end else if (tx_low > 0) begin
      tx_low--;
      if (tx_low == 0) tx_ready = 1'b1;
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Scoreboard: every launch must carry the oldest outstanding pushed word.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      logic [63:0] exp_w;
      launches++;
      n_checks++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL valid_width: valid high on consecutive cycles, required single-cycle pulse");
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL launch_order: unexpected launch data=%h, no word outstanding", data);
      end else begin
        exp_w = sb.pop_front();
        if (data !== exp_w) begin
          n_fail++;
          $display("FAIL launch_order: data=%h required %h", data, exp_w);
        end
      end
      held_data = data;
    end else if (rst_n && busy) begin
      n_checks++;
      if (data !== held_data) begin
        n_fail++;
        $display("FAIL data_hold: data=%h changed while busy, required %h", data, held_data);
      end
    end
    prev_valid = rst_n && valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || !empty) && n < bound) begin step(); n++; end
    n_checks++;
    if (busy || !empty) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%0b empty=%0b after %0d cycles, required idle", busy, empty, bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({valid, busy, full, ovf, tmo} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid/busy/full/ovf/tmo=%b required 00000", {valid, busy, full, ovf, tmo});
    end
    n_checks++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_queue: empty=%0b level=%0d required 1/0", empty, level);
    end
    n_checks++;
    if (data !== 64'd0 || sent !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h sent=%0d required 0/0", data, sent);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [63:0] w;
    logic [15:0] s0;
    int n;
    w = 64'h02002000_e_1_00000a;
    s0 = sent;
    wr_en = 1'b1; wr_data = w; sb.push_back(w);
    step();
    wr_en = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: valid=%0b one clock after push, required 0", valid);
    end
    step();
    n_checks++;
    if (valid !== 1'b1 || data !== w) begin
      n_fail++;
      $display("FAIL latency_2clk: valid=%0b data=%h required 1 / %h", valid, data, w);
    end
    step();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse: valid=%0b in cycle after launch, required 0", valid);
    end
    n = 0;
    while (tx_ready && n < 10) begin step(); n++; end
    n = 0;
    while (!tx_ready && n < 200) begin step(); n++; end
    n_checks++;
    if (!tx_ready) begin
      n_fail++;
      $display("FAIL tx_model: ready=%0b, required return to 1", tx_ready);
    end
    step();
    n_checks++;
    if (sent !== 16'(s0 + 1)) begin
      n_fail++;
      $display("FAIL sent_single: sent=%0d required %0d", sent, s0 + 1);
    end
    repeat (GAP - 1) step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_hold: busy=%0b %0d clocks after ready rise, required 1", busy, GAP);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_end: busy=%0b %0d clocks after ready rise, required 0", busy, GAP + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w [4];
    logic [15:0] s0;
    int l0, t, rise_t, maxlvl;
    bit prev_rdy;
    w[0] = 64'h02002000_e_1_00000a;
    w[1] = 64'h02002000_e_2_000014;
    w[2] = 64'h02002000_e_3_00001e;
    w[3] = 64'h02002000_e_4_000028;
    s0 = sent; l0 = launches; maxlvl = 0; rise_t = -1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = w[i]; sb.push_back(w[i]);
      step();
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    wr_en = 1'b0;
    prev_rdy = tx_ready;
    t = 0;
    while (t < 1500 && !(launches - l0 == 4 && !busy)) begin
      step(); t++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (valid && rise_t >= 0) begin
        n_checks++;
        if (t - rise_t < GAP + 1) begin
          n_fail++;
          $display("FAIL gap_spacing: launch %0d clocks after ready rise, required >= %0d", t - rise_t, GAP + 1);
        end
        rise_t = -1;
      end
      if (tx_ready && !prev_rdy) rise_t = t;
      prev_rdy = tx_ready;
    end
    n_checks++;
    if (maxlvl != 3) begin
      n_fail++;
      $display("FAIL level_peak: peak level=%0d required 3", maxlvl);
    end
    n_checks++;
    if (sent !== 16'(s0 + 4) || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: sent=%0d empty=%0b required %0d / 1", sent, empty, s0 + 4);
    end
  endtask

  task automatic test_overflow();
    int l0, n;
    tx_mode = 2;
    step(); step();
    l0 = launches;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 64'hA5A5_0000_0000_0000 | 64'(i);
      if (i < 16) sb.push_back(wr_data);
      step();
      if (i == 15) begin
        n_checks++;
        if (full !== 1'b1) begin
          n_fail++;
          $display("FAIL full_at_16: full=%0b required 1", full);
        end
      end
    end
    wr_en = 1'b0;
    n_checks++;
    if (ovf !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: ovf=%0b level=%0d full=%0b required 1/16/1", ovf, level, full);
    end
    tx_mode = 0;
    n = 0;
    while (!(launches - l0 == 16 && !busy) && n < 4000) begin step(); n++; end
    n_checks++;
    if (launches - l0 != 16 || empty !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: launches=%0d empty=%0b left=%0d required 16/1/0", launches - l0, empty, sb.size());
    end
  endtask

  task automatic test_timeout();
    logic [15:0] s0;
    int l0, n;
    tx_mode = 1;
    step();
    s0 = sent; l0 = launches;
    wr_en = 1'b1; wr_data = 64'h1111_2222_3333_4444; sb.push_back(wr_data);
    step();
    wr_data = 64'h5555_6666_7777_8888; sb.push_back(wr_data);
    step();
    wr_en = 1'b0;
    n = 0;
    while (!valid && n < 10) begin step(); n++; end
    step();
    // LAUNCH is over here; the flag must rise after exactly 8 WAIT_BUSY clocks
    repeat (7) step();
    n_checks++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: tmo=%0b after 7 clocks, required 0", tmo);
    end
    step();
    n_checks++;
    if (tmo !== 1'b1 || sent !== s0) begin
      n_fail++;
      $display("FAIL timeout_8: tmo=%0b sent=%0d required 1 / %0d", tmo, sent, s0);
    end
    tx_mode = 0;
    n = 0;
    while (!(launches - l0 == 2 && !busy) && n < 400) begin step(); n++; end
    n_checks++;
    if (launches - l0 != 2 || sent !== 16'(s0 + 1)) begin
      n_fail++;
      $display("FAIL timeout_resume: launches=%0d sent=%0d required 2 / %0d", launches - l0, sent, s0 + 1);
    end
  endtask

  task automatic test_flush();
    logic [15:0] s0;
    int l0, n;
    n_checks++;
    if (ovf !== 1'b1 || tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_flags: ovf=%0b tmo=%0b required 1/1", ovf, tmo);
    end
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 64'hF000_0000_0000_0000 | 64'(i); sb.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    n = 0;
    while (tx_ready && n < 20) begin step(); n++; end
    step(); step();
    n_checks++;
    if (level !== 5'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_flush: level=%0d busy=%0b required 5/1", level, busy);
    end
    s0 = sent; l0 = launches;
    flush = 1'b1; wr_en = 1'b1; wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    flush = 1'b0; wr_en = 1'b0;
    repeat (5) void'(sb.pop_back());
    n_checks++;
    if (level !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0 || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: level=%0d empty=%0b ovf=%0b tmo=%0b required 0/1/0/0", level, empty, ovf, tmo);
    end
    n = 0;
    while (busy && n < 300) begin step(); n++; end
    repeat (40) step();
    n_checks++;
    if (sent !== 16'(s0 + 1) || launches != l0) begin
      n_fail++;
      $display("FAIL flush_inflight: sent=%0d launches=%0d required %0d / %0d", sent, launches, s0 + 1, l0);
    end
  endtask

  task automatic test_async_reset();
    int l0, n;
    wr_en = 1'b1; wr_data = 64'hCAFE_0000_0000_0001; sb.push_back(wr_data);
    step();
    wr_data = 64'hCAFE_0000_0000_0002; sb.push_back(wr_data);
    step();
    wr_en = 1'b0;
    n = 0;
    while (tx_ready && n < 20) begin step(); n++; end
    step(); step();
    n_checks++;
    if (busy !== 1'b1 || sent === 16'd0) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%0b sent=%0d required 1 / nonzero", busy, sent);
    end
    #20;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if ({valid, busy, full, ovf, tmo} !== 5'b0 || empty !== 1'b1 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL async_flags: valid/busy/full/ovf/tmo=%b empty=%0b level=%0d required 00000/1/0",
               {valid, busy, full, ovf, tmo}, empty, level);
    end
    n_checks++;
    if (sent !== 16'd0 || data !== 64'd0) begin
      n_fail++;
      $display("FAIL async_data: sent=%0d data=%h required 0/0", sent, data);
    end
    tx_mode = 1;
    repeat (3) step();
    rst_n = 1'b1;
    held_data = '0;
    l0 = launches;
    repeat (40) step();
    n_checks++;
    if (launches != l0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: launches=%0d busy=%0b required %0d / 0", launches, busy, l0);
    end
    tx_mode = 0;
    step();
    wr_en = 1'b1; wr_data = 64'hCAFE_0000_0000_0003; sb.push_back(wr_data);
    step();
    wr_en = 1'b0;
    n = 0;
    while (!(launches - l0 == 1 && !busy) && n < 400) begin step(); n++; end
    n_checks++;
    if (sent !== 16'd1 || launches - l0 != 1) begin
      n_fail++;
      $display("FAIL post_reset_frame: sent=%0d launches=%0d required 1/1", sent, launches - l0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    wait_idle(100);
    test_back_to_back();
    wait_idle(100);
    test_overflow();
    wait_idle(100);
    test_timeout();
    wait_idle(100);
    test_flush();
    wait_idle(100);
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
